// File: rtl/four_port_switch_if.sv
// Ingress and egress signals of all four switch ports, bundled as one interface.
interface four_port_switch_if;
   logic [3:0]      valid_in;
   logic [3:0][3:0] source_in;
   logic [3:0][3:0] target_in;
   logic [3:0][7:0] data_in;
   logic [3:0]      valid_out;
   logic [3:0][3:0] source_out;
   logic [3:0][3:0] target_out;
   logic [3:0][7:0] data_out;
   logic [3:0]      fifo_full;

   modport master (
      output valid_in, source_in, target_in, data_in,
      input  valid_out, source_out, target_out, data_out, fifo_full
   );

   modport slave (
      input  valid_in, source_in, target_in, data_in,
      output valid_out, source_out, target_out, data_out, fifo_full
   );
endinterface

// File: rtl/four_port_switch.sv
// Four-port packet switch: per-input drop-on-full FIFO, per-input delivery FSM,
// per-output round-robin arbiter with registered outputs.
//   state  | meaning
//   IDLE   | no head in service; load head target mask when FIFO non-empty
//   ACTIVE | requesting every output still set in the remaining mask
module four_port_switch #(
   parameter int DEPTH        = 8,
   parameter int PACKET_WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   four_port_switch_if.slave sw
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [PACKET_WIDTH-1:0] mem [4][DEPTH];
   logic [AW-1:0]           wr_ptr [4];
   logic [AW-1:0]           rd_ptr [4];
   logic [CW-1:0]           count [4];
   logic [PACKET_WIDTH-1:0] head [4];
   logic [3:0]              push, pop, full;

   state_t     state [4];
   state_t     state_nxt [4];
   logic [3:0] remain [4];
   logic [3:0] remain_nxt [4];

   logic [3:0] req [4];
   logic [3:0] grant [4];
   logic [3:0] gnt_in [4];
   logic [1:0] sel [4];
   logic [1:0] rr_ptr [4];
   logic [1:0] idx;

   logic [3:0]      valid_q;
   logic [3:0][3:0] source_q, target_q;
   logic [3:0][7:0] data_q;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         full[i] = (count[i] == CW'(DEPTH));
         push[i] = sw.valid_in[i] && !full[i] && (sw.target_in[i] != 4'd0);
         head[i] = mem[i][rd_ptr[i]];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (push[i]) mem[i][wr_ptr[i]] <= {sw.data_in[i], sw.target_in[i], sw.source_in[i]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (push[i]) wr_ptr[i] <= (wr_ptr[i] == AW'(DEPTH - 1)) ? '0 : wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= (rd_ptr[i] == AW'(DEPTH - 1)) ? '0 : rd_ptr[i] + 1'b1;
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + 1'b1;
               2'b01:   count[i] <= count[i] - 1'b1;
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   // Search starts at the pointer; the first requester found wins.
   always_comb begin
      idx = '0;
      for (int o = 0; o < 4; o++) begin
         req[o]   = '0;
         grant[o] = '0;
         sel[o]   = '0;
      end
      for (int o = 0; o < 4; o++)
         for (int i = 0; i < 4; i++)
            req[o][i] = (state[i] == ACTIVE) && remain[i][o];
      for (int o = 0; o < 4; o++) begin
         for (int off = 0; off < 4; off++) begin
            idx = rr_ptr[o] + 2'(off);
            if (req[o][idx] && (grant[o] == 4'd0)) begin
               grant[o][idx] = 1'b1;
               sel[o]        = idx;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         gnt_in[i] = '0;
         for (int o = 0; o < 4; o++) gnt_in[i][o] = grant[o][i];
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < 4; i++) begin
         state_nxt[i]  = state[i];
         remain_nxt[i] = remain[i];
         case (state[i])
            IDLE: begin
               if (count[i] != '0) begin
                  remain_nxt[i] = head[i][7:4];
                  state_nxt[i]  = ACTIVE;
               end
            end
            ACTIVE: begin
               remain_nxt[i] = remain[i] & ~gnt_in[i];
               if (remain_nxt[i] == 4'd0) begin
                  pop[i]       = 1'b1;
                  state_nxt[i] = IDLE;
               end
            end
            default: state_nxt[i] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            state[i]  <= IDLE;
            remain[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            state[i]  <= state_nxt[i];
            remain[i] <= remain_nxt[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= '0;
         source_q <= '0;
         target_q <= '0;
         data_q   <= '0;
         for (int o = 0; o < 4; o++) rr_ptr[o] <= '0;
      end else begin
         for (int o = 0; o < 4; o++) begin
            valid_q[o] <= |grant[o];
            if (|grant[o]) begin
               source_q[o] <= head[sel[o]][3:0];
               target_q[o] <= head[sel[o]][7:4];
               data_q[o]   <= head[sel[o]][15:8];
               rr_ptr[o]   <= sel[o] + 2'd1;
            end
         end
      end
   end

   assign sw.valid_out  = valid_q;
   assign sw.source_out = source_q;
   assign sw.target_out = target_q;
   assign sw.data_out   = data_q;
   assign sw.fifo_full  = full;
endmodule

// File: tb/tb_four_port_switch.sv
// Bench for four_port_switch: directed scenarios plus randomized traffic checked
// against per-input packet queues that track outstanding deliveries.
module tb_four_port_switch;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   four_port_switch_if sw ();

   four_port_switch #(.DEPTH(8), .PACKET_WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] src;
      logic [3:0] tgt;
      logic [3:0] rem;
      logic [7:0] data;
   } pkt_t;

   pkt_t q [4][$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   delivered = 0;
   int   accepted_copies = 0;
   int   model_drops = 0;
   int   dut_drops = 0;
   logic saw_full = 1'b0;

   function automatic int popcnt(input logic [3:0] m);
      int c = 0;
      for (int b = 0; b < 4; b++) if (m[b]) c++;
      return c;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < 4; i++) if (q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_inputs();
      sw.valid_in  = '0;
      sw.source_in = '0;
      sw.target_in = '0;
      sw.data_in   = '0;
   endtask

   task automatic drive(input int i, input logic [3:0] tgt, input logic [7:0] data);
      sw.valid_in[i]  = 1'b1;
      sw.source_in[i] = 4'(i);
      sw.target_in[i] = tgt;
      sw.data_in[i]   = data;
   endtask

   // One clock: capture presented inputs, cross the edge, then account for
   // deliveries (which retire model entries) and newly accepted packets.
   task automatic step();
      logic [3:0]      v, pre_full, obs_full;
      logic [3:0][3:0] t;
      logic [7:0]      d [4];
      logic            rst_edge;
      pkt_t            p;
      int              k;
      v        = sw.valid_in;
      t        = sw.target_in;
      obs_full = sw.fifo_full;
      rst_edge = !rst_n;
      for (int i = 0; i < 4; i++) begin
         d[i]        = sw.data_in[i];
         pre_full[i] = (q[i].size() == 8);
      end
      @(posedge clk);
      @(negedge clk);
      if (rst_edge) begin
         for (int i = 0; i < 4; i++) q[i].delete();
         return;
      end
      for (int i = 0; i < 4; i++) if (v[i] && obs_full[i]) dut_drops++;
      for (int o = 0; o < 4; o++) begin
         if (sw.valid_out[o]) begin
            k = int'(sw.source_out[o]);
            n_cmp++;
            if (k > 3 || q[k % 4].size() == 0 || !q[k % 4][0].rem[o] ||
                q[k % 4][0].tgt !== sw.target_out[o] || q[k % 4][0].data !== sw.data_out[o]) begin
               n_fail++;
               $display("FAIL delivery out%0d: got src=%0d tgt=%b data=%h, no matching pending head",
                        o, k, sw.target_out[o], sw.data_out[o]);
            end else begin
               p = q[k][0];
               p.rem[o] = 1'b0;
               q[k][0] = p;
               delivered++;
               if (p.rem == 4'd0) void'(q[k].pop_front());
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (v[i] && t[i] != 4'd0) begin
            if (pre_full[i]) model_drops++;
            else begin
               p.src = 4'(i); p.tgt = t[i]; p.rem = t[i]; p.data = d[i];
               q[i].push_back(p);
               accepted_copies += popcnt(t[i]);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (sw.fifo_full[i] !== (q[i].size() == 8)) begin
            n_fail++;
            $display("FAIL fifo_full[%0d]: got %b, required %b (occupancy %0d)",
                     i, sw.fifo_full[i], (q[i].size() == 8), q[i].size());
         end
         if (sw.fifo_full[i]) saw_full = 1'b1;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int c = 0; c < 300 && !all_empty(); c++) step();
      n_cmp++;
      if (!all_empty()) begin
         n_fail++;
         $display("FAIL %s drain: packets still pending after 300 cycles, required none", name);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (sw.valid_out !== 4'd0 || sw.fifo_full !== 4'd0) begin
         n_fail++;
         $display("FAIL reset flags: valid_out=%b fifo_full=%b, required 0000/0000", sw.valid_out, sw.fifo_full);
      end
      n_cmp++;
      if (sw.source_out !== '0 || sw.target_out !== '0 || sw.data_out !== '0) begin
         n_fail++;
         $display("FAIL reset fields: src=%h tgt=%h data=%h, required all 0", sw.source_out, sw.target_out, sw.data_out);
      end
   endtask

   task automatic test_unicast();
      do_reset();
      drive(0, 4'b0010, 8'hA5);
      step();
      clear_inputs();
      step();
      n_cmp++;
      if (sw.valid_out !== 4'b0000) begin
         n_fail++;
         $display("FAIL unicast early: valid_out=%b one edge after push, required 0000", sw.valid_out);
      end
      step();
      n_cmp++;
      if (sw.valid_out !== 4'b0010 || sw.data_out[1] !== 8'hA5 || sw.source_out[1] !== 4'd0 ||
          sw.target_out[1] !== 4'b0010) begin
         n_fail++;
         $display("FAIL unicast deliver: valid=%b data=%h src=%0d tgt=%b, required 0010/a5/0/0010",
                  sw.valid_out, sw.data_out[1], sw.source_out[1], sw.target_out[1]);
      end
      step();
      n_cmp++;
      if (sw.valid_out !== 4'b0000 || sw.data_out[1] !== 8'hA5) begin
         n_fail++;
         $display("FAIL unicast hold: valid=%b data=%h, required 0000 with data held a5", sw.valid_out, sw.data_out[1]);
      end
   endtask

   task automatic test_broadcast();
      do_reset();
      drive(2, 4'b1111, 8'h3C);
      step();
      clear_inputs();
      step();
      step();
      n_cmp++;
      if (sw.valid_out !== 4'b1111 || sw.data_out !== {4{8'h3C}} || sw.source_out !== {4{4'd2}}) begin
         n_fail++;
         $display("FAIL broadcast: valid=%b data=%h src=%h, required 1111/3c x4/2 x4",
                  sw.valid_out, sw.data_out, sw.source_out);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         n_cmp++;
         if (sw.valid_out !== 4'b0000) begin
            n_fail++;
            $display("FAIL broadcast repeat: valid=%b on cycle %0d after delivery, required 0000", sw.valid_out, c + 1);
         end
      end
   endtask

   task automatic test_contention();
      do_reset();
      for (int i = 0; i < 3; i++) drive(i, 4'b1000, 8'(8'h10 + i));
      step();
      clear_inputs();
      step();
      for (int j = 0; j < 3; j++) begin
         step();
         n_cmp++;
         if (sw.valid_out !== 4'b1000 || sw.source_out[3] !== 4'(j) || sw.data_out[3] !== 8'(8'h10 + j)) begin
            n_fail++;
            $display("FAIL contention slot %0d: valid=%b src=%0d data=%h, required 1000/%0d/%h",
                     j, sw.valid_out, sw.source_out[3], sw.data_out[3], j, 8'(8'h10 + j));
         end
      end
      step();
      n_cmp++;
      if (sw.valid_out !== 4'b0000) begin
         n_fail++;
         $display("FAIL contention tail: valid=%b, required 0000", sw.valid_out);
      end
   endtask

   task automatic test_multicast_split();
      do_reset();
      drive(0, 4'b0110, 8'h11);
      drive(1, 4'b0100, 8'h22);
      step();
      clear_inputs();
      step();
      step();
      n_cmp++;
      if (sw.valid_out !== 4'b0110 || sw.source_out[1] !== 4'd0 || sw.source_out[2] !== 4'd0 ||
          sw.data_out[2] !== 8'h11) begin
         n_fail++;
         $display("FAIL multicast first: valid=%b src1=%0d src2=%0d data2=%h, required 0110/0/0/11",
                  sw.valid_out, sw.source_out[1], sw.source_out[2], sw.data_out[2]);
      end
      step();
      n_cmp++;
      if (sw.valid_out !== 4'b0100 || sw.source_out[2] !== 4'd1 || sw.data_out[2] !== 8'h22) begin
         n_fail++;
         $display("FAIL multicast second: valid=%b src2=%0d data2=%h, required 0100/1/22",
                  sw.valid_out, sw.source_out[2], sw.data_out[2]);
      end
      step();
      n_cmp++;
      if (sw.valid_out !== 4'b0000) begin
         n_fail++;
         $display("FAIL multicast tail: valid=%b, required 0000", sw.valid_out);
      end
   endtask

   task automatic test_overflow();
      int del0, md0, dd0, acc0;
      do_reset();
      del0 = delivered; md0 = model_drops; dd0 = dut_drops; acc0 = accepted_copies;
      saw_full = 1'b0;
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < 4; i++) drive(i, 4'b0001, 8'($urandom));
         step();
      end
      clear_inputs();
      drain("overflow");
      n_cmp++;
      if (saw_full !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow full: fifo_full never asserted, required assertion");
      end
      n_cmp++;
      if ((delivered - del0) + (dut_drops - dd0) != 80) begin
         n_fail++;
         $display("FAIL overflow conservation: delivered %0d + dropped %0d, required sum 80",
                  delivered - del0, dut_drops - dd0);
      end
      n_cmp++;
      if ((dut_drops - dd0) != (model_drops - md0) || (delivered - del0) != (accepted_copies - acc0)) begin
         n_fail++;
         $display("FAIL overflow accounting: drops %0d delivered %0d, required drops %0d delivered %0d",
                  dut_drops - dd0, delivered - del0, model_drops - md0, accepted_copies - acc0);
      end
   endtask

   task automatic test_random();
      int del0, acc0;
      do_reset();
      del0 = delivered; acc0 = accepted_copies;
      for (int c = 0; c < 400; c++) begin
         clear_inputs();
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 99) < 55) drive(i, 4'($urandom_range(0, 15)), 8'($urandom));
         step();
      end
      clear_inputs();
      drain("random");
      n_cmp++;
      if ((delivered - del0) != (accepted_copies - acc0)) begin
         n_fail++;
         $display("FAIL random conservation: delivered %0d, required %0d",
                  delivered - del0, accepted_copies - acc0);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < 4; i++) drive(i, 4'($urandom_range(1, 3)), 8'($urandom));
         step();
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      clear_inputs();
      n_cmp++;
      if (sw.valid_out !== 4'd0 || sw.fifo_full !== 4'd0 || sw.data_out !== '0) begin
         n_fail++;
         $display("FAIL midreset state: valid=%b full=%b data=%h, required all 0",
                  sw.valid_out, sw.fifo_full, sw.data_out);
      end
      for (int c = 0; c < 12; c++) begin
         step();
         n_cmp++;
         if (sw.valid_out !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset stale: valid=%b %0d cycles after reset, required 0000", sw.valid_out, c + 1);
         end
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_unicast();
      test_broadcast();
      test_contention();
      test_multicast_split();
      test_overflow();
      test_random();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
